// File: rtl/dump_sequencer.sv
// Walks one channel's circular sample buffer oldest-first and sends each byte
// over UART (trmt/tx_done). Ports: clk, rst_n, dump/dump_chan/waddr_start in,
// rdata/tx_done in, raddr/chan_sel/trmt/tx_data/busy/dump_done/clr_cap_done out.
module dump_sequencer #(
  parameter int          ENTRIES  = 384,
  parameter int          LOG2     = 9,
  parameter int          NUM_CH   = 5,
  parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] waddr_start,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic [LOG2-1:0] raddr,
  output logic [2:0]      chan_sel,
  output logic            trmt,
  output logic [7:0]      tx_data,
  output logic            busy,
  output logic            dump_done,
  output logic            clr_cap_done
);

  typedef enum logic [2:0] {
    IDLE, RD, XMIT, WAIT_TX, NAK, DONE
  } state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          state, state_n;
  logic [LOG2-1:0] cnt, cnt_n;
  logic [LOG2-1:0] raddr_n;
  logic [2:0]      chan_n;
  logic [7:0]      tx_data_n;
  logic            trmt_n, busy_n;
  logic            nak, nak_n;
  logic            chan_ok;

  assign chan_ok = ({1'b0, dump_chan} < 4'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      raddr    <= '0;
      chan_sel <= '0;
      tx_data  <= '0;
      trmt     <= 1'b0;
      busy     <= 1'b0;
      nak      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      raddr    <= raddr_n;
      chan_sel <= chan_n;
      tx_data  <= tx_data_n;
      trmt     <= trmt_n;
      busy     <= busy_n;
      nak      <= nak_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    raddr_n      = raddr;
    chan_n       = chan_sel;
    tx_data_n    = tx_data;
    trmt_n       = 1'b0;
    busy_n       = busy;
    nak_n        = nak;
    dump_done    = 1'b0;
    clr_cap_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (dump && chan_ok) begin
          chan_n  = dump_chan;
          cnt_n   = '0;
          busy_n  = 1'b1;
          nak_n   = 1'b0;
          // an out-of-range start pointer falls back to the buffer base
          raddr_n = (waddr_start > LAST) ? '0 : waddr_start;
          state_n = RD;
        end else if (dump) begin
          tx_data_n = NAK_BYTE;
          trmt_n    = 1'b1;
          busy_n    = 1'b1;
          nak_n     = 1'b1;
          state_n   = NAK;
        end
      end
      RD: state_n = XMIT;
      XMIT: begin
        tx_data_n = rdata;
        trmt_n    = 1'b1;
        state_n   = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          if (cnt == LAST) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + 1'b1;
            raddr_n = (raddr == LAST) ? '0 : raddr + 1'b1;
            state_n = RD;
          end
        end
      end
      NAK: begin
        if (tx_done) state_n = DONE;
      end
      DONE: begin
        dump_done    = 1'b1;
        clr_cap_done = !nak;
        busy_n       = 1'b0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Controls the post-capture readout of the sample RAMs.
- On a dump command for one channel, it walks that channel's circular sample buffer from oldest to newest entry, one RAM read per byte.
- Each sample byte is handed to the UART transmitter with a trmt/tx_done handshake.
- On completion it pulses dump_done to the command processor and clears capture_done so a new capture can be armed.
- Sits between the command processing SM, the per-channel RAM queues (read side) and the UART transmitter.

Parameters:
- ENTRIES, 384, number of RAM locations per channel (12288 on DE0).
- LOG2, 9, address/counter width; ENTRIES <= 2**LOG2.
- NUM_CH, 5, number of valid channels; indices 0..NUM_CH-1.
- NAK_BYTE, 8'hEE, byte sent when the requested channel is invalid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- dump  in  1  one-cycle dump request from command SM
- dump_chan  in  3  channel to dump; sampled with dump
- waddr_start  in  LOG2  oldest-sample address (capture's write pointer); sampled with dump
- rdata  in  8  muxed RAM read data; valid the cycle after raddr is presented
- tx_done  in  1  UART pulse: byte finished
- raddr  out  LOG2  RAM read address (registered)
- chan_sel  out  3  registered channel select for the RAM read mux
- trmt  out  1  one-cycle transmit strobe (registered)
- tx_data  out  8  byte to transmit (registered, held until next load)
- busy  out  1  high from dump acceptance until the DONE cycle inclusive
- dump_done  out  1  one-cycle completion pulse
- clr_cap_done  out  1  one-cycle pulse to clear capture_done; valid channel only

Behaviour:
- Reset: state IDLE; raddr=0, chan_sel=0, tx_data=0, byte count=0, trmt=0, busy=0, dump_done=0, clr_cap_done=0.
- States: IDLE, RD, XMIT, WAIT_TX, NAK, DONE.
- IDLE, dump=1 and dump_chan<NUM_CH:
  - chan_sel<=dump_chan; cnt<=0; busy<=1; go to RD.
  - raddr<=waddr_start, or 0 if waddr_start>=ENTRIES.
- IDLE, dump=1 and dump_chan>=NUM_CH:
  - tx_data<=NAK_BYTE; trmt<=1; busy<=1; go to NAK.
  - No RAM address change.
- RD: one wait cycle for RAM latency; go to XMIT.
- XMIT: tx_data<=rdata; trmt<=1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX, on tx_done:
  - If cnt==ENTRIES-1, go to DONE.
  - Otherwise cnt<=cnt+1; raddr<=(raddr==ENTRIES-1)?0:raddr+1; go to RD.
- NAK: on tx_done, go to DONE with an internal flag that suppresses clr_cap_done.
- DONE: dump_done=1 and clr_cap_done=1 (unless NAK) for one cycle; busy<=0; go to IDLE.
- Latency:
  - dump sampled at edge E0 -> trmt high after E2 with tx_data=mem[start].
  - Per byte: tx_done edge -> next trmt two edges later.
- Exactly ENTRIES bytes per valid dump, oldest first, address wrapping ENTRIES-1 -> 0.
- Ignored inputs:
  - dump while busy: ignored, no effect on counters or state.
  - tx_done outside WAIT_TX/NAK: ignored.
  - tx_done in the same cycle trmt is high: accepted (counts as completion).
- rst_n low mid-dump: immediate return to reset values; no dump_done or clr_cap_done emitted; a partially sent byte is the UART's concern.

Test Plan:
- NUM_CH=5, ENTRIES=384; mem[ch2][a]=a[7:0]; dump_chan=2, waddr_start=0; tx_done 10 cycles after each trmt:
  - 384 trmt pulses with bytes 0x00..0xFF,0x00..0x7F.
  - One dump_done and one clr_cap_done.
  - busy low afterward.
- waddr_start=380:
  - raddr sequence 380,381,382,383,0,1,...,379.
  - First byte 0x7C, 5th byte 0x00, last byte mem[379]=0x7B.
- dump_chan=6:
  - Single trmt with tx_data=0xEE; raddr unchanged.
  - After tx_done: dump_done pulse, clr_cap_done stays 0.
- Second dump pulse at byte 10 of an active dump, plus a spurious tx_done while in RD:
  - Byte stream and count unchanged; still exactly 384 bytes.
- rst_n asserted after byte 100:
  - All outputs return to reset values the same cycle; no dump_done.
  - A new dump afterward starts cleanly from its sampled waddr_start.
- tx_done returned in the same cycle as trmt for all bytes:
  - Full dump completes in 384*3+1 cycles after acceptance, with correct data order.
